// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller with Sel alternation
// Optional leading-zero blanking of Mil/Cen/Dec when DISP_BLANK_ZERO_EN is defined.
module display_scan_ctrl #(
  parameter int REFRESH_DIV   = 50000,
  parameter int TOGGLE_FRAMES = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Uni,
  input  logic [3:0] Dec,
  input  logic [3:0] Cen,
  input  logic [3:0] Mil,
  input  logic       Modo,
  input  logic       Btn_Sel,
  output logic       Sel,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FR_W  = (TOGGLE_FRAMES > 1) ? $clog2(TOGGLE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(TOGGLE_FRAMES - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [FR_W-1:0]  fcnt_q, fcnt_d;
  logic             pend_q, pend_d;
  logic [2:0]       sync_q, sync_d;
  logic [15:0]      snap_q, snap_d;
  logic             sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       scanning;
  logic       tick;
  logic       frame_end;
  logic       btn_rise;
  logic [3:0] digit;
  logic       blank_digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_MINUS;
    endcase
    return s;
  endfunction

  assign scanning  = (state_q == ST_SCAN);
  assign tick      = scanning && (div_q == DIV_MAX);
  assign frame_end = tick && (idx_q == 2'd3);
  assign btn_rise  = sync_q[1] & ~sync_q[2];
  assign digit     = snap_q[{idx_q, 2'b00} +: 4];

`ifdef DISP_BLANK_ZERO_EN
  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    blank_digit = 1'b0;
    case (idx_q)
      2'd3:    blank_digit = (snap_q[15:12] == 4'd0);
      2'd2:    blank_digit = (snap_q[15:8] == 8'd0);
      2'd1:    blank_digit = (snap_q[15:4] == 12'd0);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      ST_LOAD: begin
        state_d = ST_SCAN;
        snap_d  = {Mil, Cen, Dec, Uni};
        div_d   = '0;
        idx_d   = 2'd0;
      end
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          idx_d = idx_q + 2'd1;
        end
        if (frame_end) begin
          state_d = ST_LOAD;
        end
      end
    endcase
  end

  // Sel only moves at a frame boundary, so the encoder settles before the next LOAD.
  always_comb begin
    sync_d = {sync_q[1:0], Btn_Sel};
    fcnt_d = fcnt_q;
    sel_d  = sel_q;
    pend_d = pend_q;
    if (Modo) begin
      fcnt_d = '0;
      if (frame_end && pend_q) begin
        sel_d = ~sel_q;
      end
      if (btn_rise) begin
        pend_d = 1'b1;
      end else if (frame_end) begin
        pend_d = 1'b0;
      end
    end else begin
      pend_d = 1'b0;
      if (frame_end) begin
        if (fcnt_q == FR_MAX) begin
          fcnt_d = '0;
          sel_d  = ~sel_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (scanning) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank_digit ? SEG_BLANK : seg7(digit);
      dp_d  = ~(sel_q && (idx_q == 2'd3));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      div_q   <= '0;
      idx_q   <= 2'd0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      sync_q  <= 3'b000;
      snap_q  <= 16'd0;
      sel_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      sync_q  <= sync_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign Sel = sel_q;
  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = dp_q;

endmodule
